// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DATA_W_MAX = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Widest bit counter any legal DATA_W can need.
  localparam int CNT_W = cnt_width(DATA_W_MAX);

  function automatic logic even_parity(input logic [DATA_W_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register; the serial tap is the end the data leaves from.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         load,
  input  logic         shift,
  input  logic         shift_right,
  input  logic [W-1:0] load_val,
  output logic         ser_bit
);

  logic [W-1:0] sr_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= load_val;
    end else if (shift) begin
      if (shift_right) begin
        sr_reg <= {1'b0, sr_reg[W-1:1]};
      end else begin
        sr_reg <= {sr_reg[W-2:0], 1'b0};
      end
    end
  end

  assign ser_bit = shift_right ? sr_reg[0] : sr_reg[W-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and frame qualifier.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              done
);

  localparam int CW = (cnt_width(DATA_W) <= CNT_W) ? cnt_width(DATA_W) : CNT_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
`ifdef PISO_TX_PARITY_EN
  localparam int PAR_POS = (LSB_FIRST != 0) ? 0 : DATA_W - 1;
`else
  localparam logic [CW-1:0] LAST_M1 = CW'(DATA_W - 2);
`endif

  state_t          state_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic            frame_reg;
  logic            done_reg;
  logic            at_last_data;
  logic            frame_end;
  logic            accept;
  logic            sr_load;
  logic            sr_shift;
  logic [DATA_W-1:0] sr_load_val;
`ifdef PISO_TX_PARITY_EN
  logic            parity_reg;
`endif

  assign at_last_data = (state_reg == SHIFT) && (bit_cnt_reg == LAST_IDX);
`ifdef PISO_TX_PARITY_EN
  assign frame_end = (state_reg == PARITY);
`else
  assign frame_end = at_last_data;
`endif

  assign load_ready = !sys_rst && ((state_reg == IDLE) || frame_end);
  assign accept     = load_valid && load_ready;

  // Loading zeros at frame end keeps ser_out low whenever the line is idle.
  always_comb begin
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = '0;
    if (accept) begin
      sr_load     = 1'b1;
      sr_load_val = load_data;
    end else if (at_last_data) begin
      sr_load = 1'b1;
`ifdef PISO_TX_PARITY_EN
      sr_load_val[PAR_POS] = parity_reg;
`endif
    end else if (frame_end) begin
      sr_load = 1'b1;
    end else if (state_reg == SHIFT) begin
      sr_shift = 1'b1;
    end
  end

  piso_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .load        (sr_load),
    .shift       (sr_shift),
    .shift_right (LSB_FIRST != 0),
    .load_val    (sr_load_val),
    .ser_bit     (ser_out)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      frame_reg   <= 1'b0;
      done_reg    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      // An accept can only occur in IDLE or on the final cycle of a frame.
      if (accept) begin
        state_reg   <= SHIFT;
        bit_cnt_reg <= '0;
        frame_reg   <= 1'b1;
`ifdef PISO_TX_PARITY_EN
        parity_reg  <= even_parity(DATA_W_MAX'(load_data));
`endif
      end else begin
        case (state_reg)
          SHIFT: begin
            if (bit_cnt_reg != LAST_IDX) begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
`ifndef PISO_TX_PARITY_EN
              done_reg    <= (bit_cnt_reg == LAST_M1);
`endif
            end else begin
`ifdef PISO_TX_PARITY_EN
              state_reg   <= PARITY;
              bit_cnt_reg <= '0;
              done_reg    <= 1'b1;
`else
              state_reg   <= IDLE;
              bit_cnt_reg <= '0;
              frame_reg   <= 1'b0;
`endif
            end
          end
`ifdef PISO_TX_PARITY_EN
          PARITY: begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            frame_reg   <= 1'b0;
          end
`endif
          default: begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            frame_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ser_frame = frame_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one LSB-first and one MSB-first instance.
module tb_piso_tx;

  localparam int DATA_W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              valid_l = 1'b0;
  logic              valid_m = 1'b0;
  logic [DATA_W-1:0] data_l  = '0;
  logic [DATA_W-1:0] data_m  = '0;
  logic              ready_l, ready_m;
  logic              out_l, out_m;
  logic              frame_l, frame_m;
  logic              done_l, done_m;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  piso_tx #(.DATA_W(DATA_W), .LSB_FIRST(1)) dut_lsb (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load_valid (valid_l),
    .load_ready (ready_l),
    .load_data  (data_l),
    .ser_out    (out_l),
    .ser_frame  (frame_l),
    .done       (done_l)
  );

  piso_tx #(.DATA_W(DATA_W), .LSB_FIRST(0)) dut_msb (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load_valid (valid_m),
    .load_ready (ready_m),
    .load_data  (data_m),
    .ser_out    (out_m),
    .ser_frame  (frame_m),
    .done       (done_m)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input bit sel, input string tag,
                           input logic o, input logic f, input logic d, input logic r);
    check({tag, ".ser_out"},    sel ? out_m   : out_l,   o);
    check({tag, ".ser_frame"},  sel ? frame_m : frame_l, f);
    check({tag, ".done"},       sel ? done_m  : done_l,  d);
    check({tag, ".load_ready"}, sel ? ready_m : ready_l, r);
  endtask

  // Called at a negedge; returns at the negedge after the frame where idle is checked.
  // pat holds the data bits in send order, first bit in pat[DATA_W-1].
  task automatic send(input bit sel, input logic [DATA_W-1:0] data,
                      input logic [DATA_W-1:0] pat, input logic par, input string tag);
    logic exp_bit;
    if (sel) begin valid_m = 1'b1; data_m = data; end
    else     begin valid_l = 1'b1; data_l = data; end
    check({tag, ".ready_before"}, sel ? ready_m : ready_l, 1'b1);
    @(negedge sys_clk);
    if (sel) begin valid_m = 1'b0; data_m = ~data; end
    else     begin valid_l = 1'b0; data_l = ~data; end
    for (int k = 0; k < FL; k++) begin
      exp_bit = (k < DATA_W) ? pat[DATA_W-1-k] : par;
      check_out(sel, $sformatf("%s.bit%0d", tag, k), exp_bit, 1'b1, k == FL-1, k == FL-1);
      $display("%s bit%0d ser_out=%b frame=%b done=%b", tag, k,
               sel ? out_m : out_l, sel ? frame_m : frame_l, sel ? done_m : done_l);
      @(negedge sys_clk);
    end
    check_out(sel, {tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic exp_bit;
    repeat (2) @(negedge sys_clk);
    check("reset.load_ready_forced", ready_l, 1'b0);
    check_out(1'b0, "reset.lsb", 1'b0, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check_out(1'b0, $sformatf("idle%0d.lsb", i), 1'b0, 1'b0, 1'b0, 1'b1);
      check_out(1'b1, $sformatf("idle%0d.msb", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    send(1'b0, 8'hA5, 8'b10100101, 1'b0, "lsb_a5");
    send(1'b1, 8'hA5, 8'b10100101, 1'b0, "msb_a5");
    send(1'b1, 8'h3C, 8'b00111100, 1'b0, "msb_3c");
    send(1'b0, 8'h07, 8'b11100000, 1'b1, "lsb_07");

    // Back-to-back: valid held through the first frame, data changes early.
    valid_l = 1'b1;
    data_l  = 8'hFF;
    @(negedge sys_clk);
    data_l = 8'h00;
    for (int k = 0; k < 2*FL; k++) begin
      exp_bit = (k < DATA_W) ? 1'b1 : 1'b0;
      check_out(1'b0, $sformatf("b2b.cyc%0d", k), exp_bit, 1'b1,
                (k == FL-1) || (k == 2*FL-1), (k == FL-1) || (k == 2*FL-1));
      $display("b2b cyc%0d ser_out=%b frame=%b done=%b", k, out_l, frame_l, done_l);
      if (k == FL) valid_l = 1'b0;
      @(negedge sys_clk);
    end
    check_out(1'b0, "b2b.after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during bit 3 of 8'hA5, with load_valid high across the reset.
    valid_l = 1'b1;
    data_l  = 8'hA5;
    @(negedge sys_clk);
    valid_l = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_bit = (k == 0 || k == 2) ? 1'b1 : 1'b0;
      check_out(1'b0, $sformatf("abort.bit%0d", k), exp_bit, 1'b1, 1'b0, 1'b0);
      if (k < 3) @(negedge sys_clk);
    end
    sys_rst = 1'b1;
    valid_l = 1'b1;
    data_l  = 8'h0F;
    check("abort.ready_in_reset", ready_l, 1'b0);
    @(negedge sys_clk);
    check_out(1'b0, "abort.reset_cycle", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("abort reset ser_out=%b frame=%b done=%b", out_l, frame_l, done_l);
    sys_rst = 1'b0;
    valid_l = 1'b0;
    @(negedge sys_clk);
    check_out(1'b0, "abort.no_accept", 1'b0, 1'b0, 1'b0, 1'b1);

    send(1'b0, 8'h0F, 8'b11110000, 1'b0, "lsb_0f");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
